glitch_pulse_gen: RTL
=====================

GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of all timing/count fields.
REQ-002 Parameter RPT_W, default 8, width of repeat count.
REQ-003 clk_in1  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_delay  input  CNT_W  cycles from trigger to first pulse.
REQ-006 cfg_width  input  CNT_W  pulse high time in cycles; 0 treated as 1.
REQ-007 cfg_gap  input  CNT_W  low time between pulses; 0 treated as 1.
REQ-008 cfg_repeat  input  RPT_W  pulses per burst; 0 treated as 1 in burst mode.
REQ-009 cfg_cont  input  1  1 = continuous mode (repeat until abort), 0 = burst mode.
REQ-010 arm  input  1  level; latches cfg_* and arms the generator.
REQ-011 trigger  input  1  level; starts the sequence when armed.
REQ-012 abort  input  1  level; cancels any activity.
REQ-013 glitch_out  output  1  registered glitch pulse.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle strobe on burst completion.
REQ-016 pulse_cnt  output  RPT_W  pulses emitted in current/last burst, wraps modulo 2^RPT_W.

Function
REQ-017 States SHALL be IDLE, ARMED, DELAY, PULSE, GAP.
REQ-018 IDLE -> ARMED when arm=1; cfg_* latched that cycle; pulse_cnt cleared; cfg_* ignored thereafter until next IDLE.
REQ-019 ARMED -> DELAY when trigger=1 and cfg_delay>0 (latched); -> PULSE directly when latched delay=0.
REQ-020 Trigger sampled high at edge k: glitch_out SHALL be high from edge k+D+1 for exactly W cycles (D=latched delay, W=effective width).
REQ-021 DELAY lasts exactly D cycles; PULSE exactly W cycles; GAP exactly G cycles (G=effective gap).
REQ-022 pulse_cnt increments on the edge each PULSE state is entered.
REQ-023 End of PULSE: burst mode and pulse_cnt==effective repeat -> IDLE with done=1 for one cycle; otherwise -> GAP.
REQ-024 GAP end -> PULSE; no re-trigger needed between pulses.
REQ-025 Continuous mode never terminates on count; pulse_cnt wraps 2^RPT_W-1 -> 0 without effect on sequencing.
REQ-026 glitch_out SHALL be high only in PULSE state, glitch-free, driven from a flop.
REQ-027 abort=1 in any non-IDLE state -> IDLE next edge; glitch_out low from that edge; done SHALL NOT assert.
REQ-028 abort has priority over trigger, arm, and counter expiry in the same cycle.
REQ-029 trigger in IDLE, DELAY, PULSE, GAP SHALL be ignored; arm outside IDLE ignored.
REQ-030 After done, a new arm is required before the next trigger is honoured.

Reset
REQ-031 rst=1 at an edge: state IDLE, glitch_out=0, busy=0, done=0, pulse_cnt=0, latched cfg=0.
REQ-032 Reset mid-pulse SHALL drop glitch_out on that edge; rst has priority over abort and all inputs.

Structure
REQ-033 Package glitch_pkg SHALL hold the state enum type and default CNT_W/RPT_W constants.
REQ-034 One sub-module, glitch_down_counter (loadable CNT_W down-counter with load, enable, zero flag), shared by DELAY/PULSE/GAP timing.

Verification
REQ-035 Burst: D=3, W=2, G=4, repeat=3, trigger edge 10 -> glitch_out high edges 14-15, 20-21, 26-27; done at edge 28; pulse_cnt=3.
REQ-036 Zero fields: D=0, W=0, G=0, repeat=0 -> single 1-cycle pulse at edge k+1, done next edge.
REQ-037 Continuous: W=1, G=1, RPT_W=2 -> pulse every 2 cycles; pulse_cnt sequence 1,2,3,0,1; no done.
REQ-038 Abort mid-PULSE (W=10, abort at 5th high cycle) -> glitch_out low next edge, busy low, done never asserts.
REQ-039 Reset mid-DELAY with trigger held high -> IDLE; no pulse until new arm plus trigger.
REQ-040 cfg_* changed after arm -> waveform matches values latched at arm.

Source files
------------

// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and default widths for the glitch pulse generator
package glitch_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int RPT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

endpackage

// File: rtl/glitch_pulse_gen_if.sv
// rtl/glitch_pulse_gen_if.sv - configuration, control and status bundle of the glitch pulse generator
//   master: drives cfg_*, arm, trigger, abort; observes glitch_out, busy, done, pulse_cnt
//   slave : the generator itself
interface glitch_pulse_gen_if #(
    parameter int CNT_W = glitch_pkg::CNT_W_DEF,
    parameter int RPT_W = glitch_pkg::RPT_W_DEF
);
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [RPT_W-1:0] cfg_repeat;
    logic             cfg_cont;
    logic             arm;
    logic             trigger;
    logic             abort;
    logic             glitch_out;
    logic             busy;
    logic             done;
    logic [RPT_W-1:0] pulse_cnt;

    modport master (
        output cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_cont,
        output arm, trigger, abort,
        input  glitch_out, busy, done, pulse_cnt
    );

    modport slave (
        input  cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_cont,
        input  arm, trigger, abort,
        output glitch_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/glitch_down_counter.sv
// rtl/glitch_down_counter.sv - loadable down-counter timing the DELAY, PULSE and GAP phases
//   clk_in1, rst : clock and synchronous active-high reset
//   load         : load load_val (wins over en)
//   en           : decrement by one, holding at zero
//   zero         : counter value is zero (current phase is in its last cycle)
module glitch_down_counter #(
    parameter int CNT_W = glitch_pkg::CNT_W_DEF
) (
    input  logic             clk_in1,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/glitch_pulse_gen.sv
// rtl/glitch_pulse_gen.sv - armed, triggered glitch pulse generator with burst and continuous modes
//   clk_in1 : sole clock
//   rst     : synchronous active-high reset
//   bus     : slave side of glitch_pulse_gen_if (cfg_*, arm, trigger, abort in;
//             glitch_out, busy, done, pulse_cnt out, all registered)
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RPT_W = RPT_W_DEF
) (
    input  logic             clk_in1,
    input  logic             rst,
    glitch_pulse_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    state_e state_q, state_d;

    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             cont_q, cont_d;
    logic             trig_q, trig_d;
    logic             glitch_q, glitch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RPT_W-1:0] pcnt_q, pcnt_d;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             take_cfg;
    logic [RPT_W-1:0] rpt_eff;
    logic             burst_last;

    // Counters are loaded with (length - 1) so the zero flag marks the last
    // cycle of a phase; zero-length width/gap collapse to one cycle.
    logic [CNT_W-1:0] dly_load, wid_load, gap_load;
    assign dly_load = dly_q - CNT_ONE;
    assign wid_load = (wid_q == '0) ? '0 : (wid_q - CNT_ONE);
    assign gap_load = (gap_q == '0) ? '0 : (gap_q - CNT_ONE);

    assign rpt_eff    = (rpt_q == '0) ? RPT_ONE : rpt_q;
    assign burst_last = !cont_q && (pcnt_q == rpt_eff);

    glitch_down_counter #(.CNT_W(CNT_W)) u_timer (
        .clk_in1  (clk_in1),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.arm) state_d = ST_ARMED;
            ST_ARMED: if (trig_q) state_d = (dly_q == '0) ? ST_PULSE : ST_DELAY;
            ST_DELAY: if (cnt_zero) state_d = ST_PULSE;
            ST_PULSE: if (cnt_zero) state_d = burst_last ? ST_IDLE : ST_GAP;
            ST_GAP:   if (cnt_zero) state_d = ST_PULSE;
            default:  state_d = ST_IDLE;
        endcase
        // Abort overrides every other transition, including arm from IDLE.
        if (bus.abort) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        take_cfg = (state_q == ST_IDLE) && (state_d == ST_ARMED);
        dly_d    = take_cfg ? bus.cfg_delay  : dly_q;
        wid_d    = take_cfg ? bus.cfg_width  : wid_q;
        gap_d    = take_cfg ? bus.cfg_gap    : gap_q;
        rpt_d    = take_cfg ? bus.cfg_repeat : rpt_q;
        cont_d   = take_cfg ? bus.cfg_cont   : cont_q;

        // Trigger is only captured while armed, so a level left high from
        // IDLE or an earlier burst needs a fresh arm before it counts.
        trig_d   = bus.trigger && (state_q == ST_ARMED) && !bus.abort;

        cnt_load = (state_d != state_q);
        cnt_en   = (state_q == ST_DELAY) || (state_q == ST_PULSE) || (state_q == ST_GAP);
        case (state_d)
            ST_DELAY: cnt_val = dly_load;
            ST_PULSE: cnt_val = wid_load;
            ST_GAP:   cnt_val = gap_load;
            default:  cnt_val = '0;
        endcase

        pcnt_d = pcnt_q;
        if (take_cfg) begin
            pcnt_d = '0;
        end else if ((state_d == ST_PULSE) && (state_q != ST_PULSE)) begin
            pcnt_d = pcnt_q + RPT_ONE;
        end

        glitch_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_PULSE) && (state_d == ST_IDLE) && !bus.abort;
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            dly_q    <= '0;
            wid_q    <= '0;
            gap_q    <= '0;
            rpt_q    <= '0;
            cont_q   <= 1'b0;
            trig_q   <= 1'b0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            dly_q    <= dly_d;
            wid_q    <= wid_d;
            gap_q    <= gap_d;
            rpt_q    <= rpt_d;
            cont_q   <= cont_d;
            trig_q   <= trig_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign bus.glitch_out = glitch_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pulse_cnt  = pcnt_q;
endmodule
